// File: rtl/adder_arbiter_v.sv
// ----------------------------------------------------------------------------
// adder_arbiter_v
//
// Shares one simple_adder_v between four requesters. A round-robin grant picks
// one requester while idle, its operands are registered, summed in the next
// cycle and the tagged sum is then held on the result channel until taken.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid and ready are both 1. A requester keeps req_valid and its operands
// stable until it sees its req_ready bit; it may withdraw before that. The
// result channel keeps result/res_id stable while res_valid=1 and res_ready=0.
//
// Parameters:
//   W           operand / result width (default 8)
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   req_valid   [3:0]    bit i: requester i presents an operand pair
//   req_ready   [3:0]    bit i: requester i granted this cycle (one-hot or 0)
//   req_x_0     [4*W-1:0] operand 0, requester i at [i*W +: W]
//   req_x_1     [4*W-1:0] operand 1, same packing
//   res_valid            result available
//   res_ready            consumer accepts the result
//   result      [W-1:0]  registered sum
//   res_id      [1:0]    requester index owning result
//
// Build option:
//   ADDER_ARB_SAT_EN  when defined, the sum saturates to all ones on carry-out;
//                     otherwise it wraps modulo 2^W.
// ----------------------------------------------------------------------------

// Plain W-bit adder with carry-out on the top bit of sum_o.
module simple_adder_v #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);
  assign sum_o = {1'b0, a_i} + {1'b0, b_i};
endmodule

module adder_arbiter_v #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  output logic [3:0]     req_ready,
  input  logic [4*W-1:0] req_x_0,
  input  logic [4*W-1:0] req_x_1,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   result,
  output logic [1:0]     res_id
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [W-1:0] op0_q, op0_d;
  logic [W-1:0] op1_q, op1_d;
  logic [1:0]   id_q, id_d;
  logic [W-1:0] result_q, result_d;
  logic [1:0]   res_id_q, res_id_d;
  logic         res_valid_q, res_valid_d;

  logic         grant_found;
  logic [1:0]   grant_idx;
  logic [W:0]   add_sum;
  logic [W-1:0] sum_sel;

  // Round-robin search: first asserted req_valid starting at ptr_q. The 2-bit
  // addition wraps 3 -> 0 on its own.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!grant_found && req_valid[ptr_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = ptr_q + 2'(k);
      end
    end
  end

  // Grant only while idle; rst masks it so nothing is offered during reset.
  assign req_ready = (state_q == S_IDLE && grant_found && !rst)
                     ? (4'b0001 << grant_idx) : 4'b0000;

  simple_adder_v #(.W(W)) u_adder (
    .a_i   (op0_q),
    .b_i   (op1_q),
    .sum_o (add_sum)
  );

`ifdef ADDER_ARB_SAT_EN
  assign sum_sel = add_sum[W] ? {W{1'b1}} : add_sum[W-1:0];
`else
  // Carry is intentionally dropped in the wrapping build.
  logic unused_carry;
  assign unused_carry = add_sum[W];
  assign sum_sel      = add_sum[W-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    id_d        = id_q;
    result_d    = result_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          op0_d   = req_x_0[grant_idx*W +: W];
          op1_d   = req_x_1[grant_idx*W +: W];
          id_d    = grant_idx;
          ptr_d   = grant_idx + 2'd1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        result_d    = sum_sel;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        // Handoff returns to IDLE; the next grant is evaluated a cycle later.
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 2'd0;
      op0_q       <= '0;
      op1_q       <= '0;
      id_q        <= 2'd0;
      result_q    <= '0;
      res_id_q    <= 2'd0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      id_q        <= id_d;
      result_q    <= result_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign res_id    = res_id_q;

endmodule
